// File: rtl/sprite_rom_arbiter_if.sv
// rtl/sprite_rom_arbiter_if.sv - requester/frame-RAM bus bundle for the sprite ROM arbiter
// Purpose: groups the request, RAM and read-return signals of the arbiter.
// Ports (slave = arbiter side):
//   req, req_addr     requester read requests and packed addresses (in)
//   gnt               one-hot grant, combinational (out)
//   mem_addr          shared frame RAM address (out)
//   mem_data          frame RAM read data, 1-cycle latency (in)
//   rd_valid, rd_data one-hot result owner and returned palette index (out)
//   oob_err           sticky out-of-range flag (out)
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic                      oob_err;

    modport master (
        output req, req_addr, mem_data,
        input  gnt, mem_addr, rd_valid, rd_data, oob_err
    );

    modport slave (
        input  req, req_addr, mem_data,
        output gnt, mem_addr, rd_valid, rd_data, oob_err
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin arbiter sharing one frame RAM among sprite requesters
// Purpose: grants one requester per cycle (round-robin from rr_ptr), drives the
// granted address to the frame RAM and returns the read data two cycles later
// tagged with a one-hot owner. Out-of-range addresses are still granted but read
// as 0 and set a sticky error flag.
// Ports:
//   Clk    clock, all state on rising edge
//   Reset  asynchronous active-high reset
//   bus    sprite_rom_arbiter_if slave modport (see interface file)
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 4,
    parameter int SHEET_WORDS = 35344
) (
    input  logic                 Clk,
    input  logic                 Reset,
    sprite_rom_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [63:0] SHEET_LIM = 64'(SHEET_WORDS);

    logic [PTR_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

    logic [NUM_REQ-1:0] gnt_c;
    logic [PTR_W-1:0]   gnt_idx;
    logic               found;
    logic [PTR_W-1:0]   idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic               oob_c;

    logic [NUM_REQ-1:0] s1_valid;
    logic               s1_oob;
    logic [NUM_REQ-1:0] rd_valid_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               oob_err_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    end

    // Search starts at rr_ptr and wraps; first active requester wins.
    always_comb begin
        gnt_c    = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        idx      = '0;
        sel_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                found      = 1'b1;
                gnt_c[idx] = 1'b1;
                gnt_idx    = idx;
                sel_addr   = addr_arr[idx];
            end
        end
        // A reset in progress must not release a grant to anyone.
        if (Reset) begin
            found    = 1'b0;
            gnt_c    = '0;
            sel_addr = '0;
        end
        oob_c = found && (64'(sel_addr) >= SHEET_LIM);
    end

    assign bus.gnt      = gnt_c;
    // Out-of-range grants still release the requester but never reach the RAM.
    assign bus.mem_addr = (found && !oob_c) ? sel_addr : '0;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.oob_err  = oob_err_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr     <= '0;
            s1_valid   <= '0;
            s1_oob     <= 1'b0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            oob_err_q  <= 1'b0;
        end else begin
            if (found) begin
                rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            end
            // Stage 1 lines up with the RAM's one-cycle read latency.
            s1_valid   <= gnt_c;
            s1_oob     <= oob_c;
            rd_valid_q <= s1_valid;
            if (|s1_valid) begin
                rd_data_q <= s1_oob ? '0 : bus.mem_data;
            end
            if (oob_c) begin
                oob_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - scoreboard testbench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SHEET_WORDS(35344)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [NUM_REQ-1:0] onehot;
        logic [DATA_W-1:0]  data;
        int                 due;
    } exp_t;

    exp_t              sb [$];
    int                pass_cnt  = 0;
    int                total_cnt = 0;
    int                cyc       = 0;
    logic [ADDR_W-1:0] addr [NUM_REQ];
    logic              exp_oob   = 1'b0;
    logic [DATA_W-1:0] last_data = '0;

    function automatic logic [DATA_W-1:0] ram_model(input logic [ADDR_W-1:0] a);
        return a[3:0] ^ a[7:4];
    endfunction

    always @(posedge clk) bus.mem_data <= ram_model(bus.mem_addr);
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic pack_addr();
        for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = addr[i];
    endtask

    // Monitor: every result must match the oldest expectation and arrive on time.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.rd_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rd_valid", 32'(bus.rd_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_valid", 32'(bus.rd_valid), 32'(e.onehot));
                    chk("rd_data", 32'(bus.rd_data), 32'(e.data));
                    chk("rd_latency", 32'(cyc), 32'(e.due));
                    last_data = e.data;
                end
            end else begin
                chk("rd_data_hold", 32'(bus.rd_data), 32'(last_data));
            end
        end
    end

    task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] exp_g,
                        input string tag);
        int                gi;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] exp_mem;
        logic              oob;
        logic [DATA_W-1:0] d;
        bus.req = r;
        pack_addr();
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_g));
        gi      = -1;
        exp_mem = '0;
        oob     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (exp_g[i]) gi = i;
        if (gi >= 0) begin
            a       = addr[gi];
            oob     = (a >= 35344);
            exp_mem = oob ? '0 : a;
            d       = oob ? '0 : ram_model(a);
            sb.push_back('{exp_g, d, cyc + 2});
        end
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(exp_mem));
        chk({tag, "_oob_err"}, 32'(bus.oob_err), 32'(exp_oob));
        if (oob) exp_oob = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [NUM_REQ-1:0] r);
        rst       = 1'b1;
        bus.req   = r;
        pack_addr();
        sb.delete();
        last_data = '0;
        exp_oob   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", 32'(bus.gnt), 32'd0);
            chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
            chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
            chk("rst_oob_err", 32'(bus.oob_err), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        addr[0] = 19'd100;
        addr[1] = 19'd21778;
        addr[2] = 19'd500;
        addr[3] = 19'd35000;
        bus.req = '0;
        pack_addr();
        do_reset(4'b1111);

        for (int i = 0; i < 8; i++) step(4'b1111, 4'(1 << (i % 4)), "rr_all");

        repeat (5) step(4'b0000, 4'b0000, "idle");
        step(4'b1111, 4'b0001, "resume");

        step(4'b0010, 4'b0010, "single1");
        step(4'b0000, 4'b0000, "idle2");

        step(4'b0100, 4'b0100, "gnt2");
        step(4'b0101, 4'b0001, "wrap0");
        step(4'b0101, 4'b0100, "then2");

        addr[3] = 19'd35343;
        step(4'b1000, 4'b1000, "edge_in");
        addr[3] = 19'd35344;
        step(4'b1000, 4'b1000, "oob3");
        step(4'b0000, 4'b0000, "oob_idle");
        step(4'b1111, 4'b0001, "after_oob0");
        step(4'b1111, 4'b0010, "after_oob1");
        addr[3] = 19'd200;

        step(4'b0001, 4'b0001, "pre_rst_a");
        do_reset(4'b0000);
        step(4'b0011, 4'b0001, "rr_reset");

        step(4'b0001, 4'b0001, "pre_rst_b");
        do_reset(4'b0000);
        step(4'b1000, 4'b1000, "post_rst3");

        repeat (3) step(4'b0000, 4'b0000, "drain");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of sprite requesters (mario, mogu, enemy, coin).
REQ-002 Parameter ADDR_W, default 19: sprite-sheet read address width.
REQ-003 Parameter DATA_W, default 4: palette index width.
REQ-004 Parameter SHEET_WORDS, default 35344: valid sprite-sheet words (188 x 188).
REQ-005 Clk  input  1: single clock; all state is on posedge Clk.
REQ-006 Reset  input  1: asynchronous, active-high reset.
REQ-007 req  input  NUM_REQ: per-requester read request, held high until granted.
REQ-008 req_addr  input  NUM_REQ*ADDR_W: packed addresses; slice i belongs to requester i and is stable while req[i] is high.
REQ-009 gnt  output  NUM_REQ: one-hot grant, valid in the same cycle as the request.
REQ-010 mem_addr  output  ADDR_W: address to the shared frame RAM.
REQ-011 mem_data  input  DATA_W: frame RAM read data, 1-cycle synchronous latency.
REQ-012 rd_valid  output  NUM_REQ: one-hot, marks the requester owning rd_data.
REQ-013 rd_data  output  DATA_W: returned palette index.
REQ-014 oob_err  output  1: sticky flag; set on any out-of-range granted address.

Function
REQ-015 The block SHALL grant at most one requester per cycle; gnt is combinational from req and rr_ptr.
REQ-016 Round-robin: the search starts at rr_ptr and proceeds ascending, wrapping at NUM_REQ-1 to 0; the first requester found with req high SHALL be granted.
REQ-017 After a grant to index i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no request, rr_ptr SHALL hold.
REQ-018 With all requests continuously high, each requester SHALL be granted exactly once in every NUM_REQ consecutive cycles.
REQ-019 mem_addr SHALL equal the granted slice of req_addr; with no grant, or with an out-of-range grant, mem_addr SHALL be 0.
REQ-020 An address is out of range when it is >= SHEET_WORDS; the grant SHALL still be issued, so the requester is released.
REQ-021 Pipeline: stage 1 registers the grant one-hot and the oob bit in the cycle after the grant; stage 2 registers mem_data, or 0 if oob, into rd_data.
REQ-022 rd_valid[i] SHALL assert exactly 2 cycles after gnt[i], for exactly 1 cycle per grant.
REQ-023 Back-to-back grants SHALL stream without bubbles; one result SHALL be returned per cycle.
REQ-024 rd_data SHALL hold its last value when rd_valid is all-zero.
REQ-025 A requester SHALL be allowed to re-request in the cycle after its grant; that request is a new transaction.
REQ-026 oob_err SHALL set in the cycle after an out-of-range grant and SHALL clear only on Reset.
REQ-027 gnt SHALL be all-zero whenever req is all-zero; gnt SHALL never be asserted for a requester whose req is low.

Reset
REQ-028 On Reset: rr_ptr=0, both pipeline stages cleared, rd_valid=0, rd_data=0, oob_err=0.
REQ-029 gnt SHALL be forced to 0 while Reset is high.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight transactions; no rd_valid pulse SHALL follow for grants issued before the reset.

Verification
REQ-031 req=4'b1111 held 8 cycles from reset, addresses valid -> gnt sequence 0001,0010,0100,1000,0001,... and rd_valid follows the same sequence 2 cycles later.
REQ-032 Only req[1] pulsed, addr=158+115*188 (21778), RAM model returns 4'd3 -> gnt[1] in cycle N, rd_valid=0010 with rd_data=3 in cycle N+2.
REQ-033 After a grant to 2, req=4'b0101 -> next grant goes to 0 (wrap from rr_ptr=3), then to 2.
REQ-034 req[3] with addr=35344 -> gnt[3] issued, mem_addr=0, rd_data=0 at N+2, oob_err=1 from N+1 and sticky.
REQ-035 Reset asserted 1 cycle after gnt[0] -> no rd_valid pulse follows; rr_ptr=0; next req=4'b1000 is granted to 3 immediately.
REQ-036 req all-zero for 5 cycles between bursts -> gnt=0, mem_addr=0, rr_ptr unchanged, rd_data holds its last value.
